// File: rtl/up_gen2.sv
// up_gen2: two-phase accumulator microcontroller with data RAM,
// return-address stack and a single I/O port pair.
module up_gen2 #(
  parameter int DATA_W      = 4,
  parameter int PC_W        = 12,
  parameter int RAM_AW      = 4,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [PC_W+3:0]   prog_data,
  input  logic [DATA_W-1:0] pushbuttons,
  output logic [PC_W-1:0]   prog_addr,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        instr,
  output logic [PC_W-1:0]   oprnd,
  output logic [DATA_W-1:0] accu,
  output logic [DATA_W-1:0] out_port,
  output logic              phase,
  output logic              c_flag,
  output logic              z_flag,
  output logic [SP_W-1:0]   sp,
  output logic              stk_err
);

  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_NORI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_IN   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t state, state_nx;

  logic [PC_W-1:0]   pc_nx, oprnd_nx;
  logic [3:0]        instr_nx;
  logic [DATA_W-1:0] accu_nx, out_nx;
  logic              c_nx, z_nx, err_nx;
  logic [SP_W-1:0]   sp_nx, sp_dec;
  logic              ram_we, push;

  logic [RAM_AW-1:0] addr;
  logic [DATA_W-1:0] imm, rd, opnd;
  logic [DATA_W:0]   sum, dif;

  logic [DATA_W-1:0] ram [2**RAM_AW];
  logic [PC_W-1:0]   stack [2**SP_W];

  generate
    if (DATA_W <= PC_W) begin : g_imm
      assign imm = oprnd[DATA_W-1:0];
    end else begin : g_imm_zx
      assign imm = {{(DATA_W-PC_W){1'b0}}, oprnd};
    end
  endgenerate

  assign addr      = oprnd[RAM_AW-1:0];
  assign rd        = ram[addr];
  assign opnd      = (instr == OP_ADD || instr == OP_SUB) ? rd : imm;
  assign sum       = {1'b0, accu} + {1'b0, opnd};
  // top bit of the widened difference is the unsigned borrow
  assign dif       = {1'b0, accu} - {1'b0, opnd};
  assign sp_dec    = sp - SP_W'(1);
  assign prog_addr = pc;
  assign phase     = (state == EXEC);

  always_comb begin
    state_nx = (state == FETCH) ? EXEC : FETCH;
    pc_nx    = pc;
    instr_nx = instr;
    oprnd_nx = oprnd;
    accu_nx  = accu;
    out_nx   = out_port;
    c_nx     = c_flag;
    z_nx     = z_flag;
    sp_nx    = sp;
    err_nx   = stk_err;
    ram_we   = 1'b0;
    push     = 1'b0;
    if (state == FETCH) begin
      instr_nx = prog_data[PC_W+3:PC_W];
      oprnd_nx = prog_data[PC_W-1:0];
      pc_nx    = pc + PC_W'(1);
    end else begin
      unique case (instr)
        OP_LIT:          accu_nx = imm;
        OP_ADDI, OP_ADD: {c_nx, accu_nx} = sum;
        OP_SUBI, OP_SUB: {c_nx, accu_nx} = dif;
        OP_NORI:         accu_nx = ~(accu | imm);
        OP_LD:           accu_nx = rd;
        OP_ST:           ram_we = 1'b1;
        OP_IN:           accu_nx = pushbuttons;
        OP_OUT:          out_nx = accu;
        OP_JMP:          pc_nx = oprnd;
        OP_JC:           if (c_flag) pc_nx = oprnd;
        OP_JZ:           if (z_flag) pc_nx = oprnd;
        OP_CALL: begin
          if (sp < SP_W'(STACK_DEPTH)) begin
            push  = 1'b1;
            sp_nx = sp + SP_W'(1);
            pc_nx = oprnd;
          end else begin
            err_nx = 1'b1;
          end
        end
        OP_RET: begin
          if (sp != '0) begin
            pc_nx = stack[sp_dec];
            sp_nx = sp_dec;
          end else begin
            err_nx = 1'b1;
          end
        end
        default: ;
      endcase
      if (instr inside {OP_LIT, OP_ADDI, OP_SUBI, OP_NORI,
                        OP_LD, OP_ADD, OP_SUB, OP_IN})
        z_nx = (accu_nx == '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= '0;
      instr    <= '0;
      oprnd    <= '0;
      accu     <= '0;
      out_port <= '0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      sp       <= '0;
      stk_err  <= 1'b0;
    end else if (enable) begin
      state    <= state_nx;
      pc       <= pc_nx;
      instr    <= instr_nx;
      oprnd    <= oprnd_nx;
      accu     <= accu_nx;
      out_port <= out_nx;
      c_flag   <= c_nx;
      z_flag   <= z_nx;
      sp       <= sp_nx;
      stk_err  <= err_nx;
    end
  end

  // reset forces FETCH at once, so an aborted EXEC never writes
  always_ff @(posedge clock) begin
    if (enable && ram_we) ram[addr] <= accu;
    if (enable && push) stack[sp] <= pc;
  end

endmodule

// File: tb/tb_up_gen2.sv
// tb_up_gen2: random and directed programs run against an
// instruction-level reference model through a scoreboard queue.
module tb_up_gen2;

  localparam int DW = 4;
  localparam int PW = 8;
  localparam int AW = 4;
  localparam int SD = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [PW+3:0] prog_data;
  logic [DW-1:0] pushbuttons = '0;
  logic [PW-1:0] prog_addr, pc, oprnd;
  logic [3:0]    instr;
  logic [DW-1:0] accu, out_port;
  logic          phase, c_flag, z_flag, stk_err;
  logic [1:0]    sp;

  logic [11:0] rom [256];
  assign prog_data = rom[prog_addr];

  always #5 clock = ~clock;

  up_gen2 #(
    .DATA_W(DW), .PC_W(PW), .RAM_AW(AW), .STACK_DEPTH(SD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .prog_data(prog_data), .pushbuttons(pushbuttons),
    .prog_addr(prog_addr), .pc(pc), .instr(instr),
    .oprnd(oprnd), .accu(accu), .out_port(out_port),
    .phase(phase), .c_flag(c_flag), .z_flag(z_flag),
    .sp(sp), .stk_err(stk_err)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] acc;
    logic [3:0] outp;
    logic       c;
    logic       z;
    logic [1:0] sp;
    logic       err;
  } st_t;

  st_t exp_q[$];
  st_t e_st, a_st;
  int  checks = 0;
  int  errors = 0;
  int  nexec = 0;
  bit  mon_on = 0;
  bit  pend = 0;

  // reference machine state
  int m_pc, m_acc, m_out, m_c, m_z, m_err, m_pb;
  int m_ram[16];
  int m_stk[$];

  function automatic void m_reset();
    m_pc = 0; m_acc = 0; m_out = 0;
    m_c = 0; m_z = 0; m_err = 0;
    m_stk.delete();
  endfunction

  function automatic void m_step();
    int w, op, opr, imm, r;
    w   = int'(rom[m_pc]);
    op  = w / 256;
    opr = w % 256;
    imm = opr % 16;
    m_pc = (m_pc + 1) % 256;
    case (op)
      1: begin m_acc = imm; m_z = (m_acc == 0); end
      2, 7: begin
        r = m_acc + ((op == 2) ? imm : m_ram[imm]);
        m_c = (r > 15); m_acc = r % 16; m_z = (m_acc == 0);
      end
      3, 8: begin
        r = (op == 3) ? imm : m_ram[imm];
        m_c = (m_acc < r); m_acc = (m_acc - r + 16) % 16;
        m_z = (m_acc == 0);
      end
      4: begin m_acc = 15 - (m_acc | imm); m_z = (m_acc == 0); end
      5: begin m_acc = m_ram[imm]; m_z = (m_acc == 0); end
      6: m_ram[imm] = m_acc;
      9: begin m_acc = m_pb; m_z = (m_acc == 0); end
      10: m_out = m_acc;
      11: m_pc = opr;
      12: if (m_c != 0) m_pc = opr;
      13: if (m_z != 0) m_pc = opr;
      14: begin
        if (m_stk.size() < SD) begin
          m_stk.push_back(m_pc); m_pc = opr;
        end else m_err = 1;
      end
      15: begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else m_err = 1;
      end
      default: ;
    endcase
  endfunction

  function automatic st_t m_snap();
    st_t s;
    s.pc   = 8'(m_pc);
    s.acc  = 4'(m_acc);
    s.outp = 4'(m_out);
    s.c    = 1'(m_c);
    s.z    = 1'(m_z);
    s.sp   = 2'(m_stk.size());
    s.err  = 1'(m_err);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  // monitor: after every enabled EXEC edge compare against the queue
  always @(negedge clock) begin
    if (pend) begin
      nexec++;
      checks++;
      a_st = {pc, accu, out_port, c_flag, z_flag, sp, stk_err};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_exec actual=%h", a_st);
      end else begin
        e_st = exp_q.pop_front();
        if (a_st !== e_st) begin
          errors++;
          $display("FAIL exec%0d actual=%h expected=%h",
                   nexec, a_st, e_st);
        end
      end
    end
    pend = mon_on && phase && enable && reset;
  end

  task automatic cyc(input bit en);
    enable = en;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 0;
    reset = 0;
    #1;
    chk("reset_state",
        {pc, instr, oprnd, accu, out_port, phase,
         c_flag, z_flag, sp, stk_err, prog_addr}, '0);
    @(posedge clock);
    #1;
    reset = 1;
    m_reset();
  endtask

  task automatic run_prog(input int n);
    int cnt, cy;
    bit en;
    for (int i = 0; i < n; i++) begin
      m_step();
      exp_q.push_back(m_snap());
    end
    cnt = 0;
    cy = 0;
    while (cnt < 2 * n && cy < 20 * n + 50) begin
      en = ($urandom_range(0, 3) != 0);
      if (en) cnt++;
      cyc(en);
      cy++;
    end
    enable = 0;
    if (cnt < 2 * n) chk("run_budget", cnt, 2 * n);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // directed program: arithmetic, RAM, I/O, stack, PC wrap
    rom[0]  = 12'h109; rom[1]  = 12'h208; rom[2]  = 12'h301;
    rom[3]  = 12'h103; rom[4]  = 12'h605; rom[5]  = 12'h100;
    rom[6]  = 12'h805; rom[7]  = 12'h505; rom[8]  = 12'h900;
    rom[9]  = 12'hA00; rom[10] = 12'hD00; rom[11] = 12'hE14;
    rom[20] = 12'hE1E; rom[30] = 12'hE28; rom[31] = 12'hF00;
    rom[21] = 12'hF00; rom[12] = 12'hF00; rom[13] = 12'hBFF;
    rom[255] = 12'h000;
    pushbuttons = 4'hA;
    m_pb = 10;
    mon_on = 1;
    run_prog(2);
    chk("addi_carry", {accu, c_flag, z_flag}, {4'h1, 1'b1, 1'b0});
    run_prog(1);
    chk("subi_zero", {accu, c_flag, z_flag}, {4'h0, 1'b0, 1'b1});
    run_prog(4);
    chk("sub_borrow", {accu, c_flag, z_flag}, {4'hD, 1'b1, 1'b0});
    run_prog(1);
    chk("ld_after_st", accu, 4'h3);
    run_prog(2);
    chk("in_out", out_port, 4'hA);
    run_prog(4);
    chk("call_overflow", {sp, stk_err, pc}, {2'd2, 1'b1, 8'd31});
    run_prog(5);
    chk("stack_final", {sp, stk_err, pc}, {2'd0, 1'b1, 8'h00});

    // random programs with a RAM-initialising prologue
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        rom[2*i]   = {4'h1, 4'h0, 4'($urandom_range(0, 15))};
        rom[2*i+1] = {4'h6, 8'(i)};
      end
      for (int i = 32; i < 256; i++)
        rom[i] = 12'($urandom_range(0, 4095));
      m_pb = $urandom_range(0, 15);
      pushbuttons = 4'(m_pb);
      run_prog(200);
    end

    // freeze during EXEC, then reset during EXEC of ST
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 12'h104; rom[1] = 12'h606; rom[2] = 12'h102;
    rom[3] = 12'h203; rom[4] = 12'h107; rom[5] = 12'h606;
    run_prog(3);
    mon_on = 0;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      cyc(0);
      chk("freeze", {pc, phase, accu, instr, oprnd},
          {8'd4, 1'b1, 4'd2, 4'h2, 8'h03});
    end
    cyc(1);
    chk("resume", {accu, c_flag, z_flag, phase, pc},
        {4'd5, 1'b0, 1'b0, 1'b0, 8'd4});
    cyc(1);
    cyc(1);
    cyc(1);
    chk("st_pending", {phase, accu, pc}, {1'b1, 4'd7, 8'd6});
    #2;
    reset = 0;
    #1;
    chk("async_reset",
        {pc, instr, oprnd, accu, out_port, phase,
         c_flag, z_flag, sp, stk_err}, '0);
    @(posedge clock);
    #1;
    enable = 0;
    rom[0] = 12'h506;
    reset = 1;
    m_reset();
    mon_on = 1;
    run_prog(1);
    chk("ram_kept", accu, 4'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
